// File: rtl/serial_add_seq.sv
// Bit-serial adder: latches two WIDTH-bit operands and adds them LSB-first with one full adder per cycle.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' input that selects op_a - op_b (two's complement).
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;

    logic             ha1_s, ha1_c, ha2_c, fa_s, fa_c;
    logic             last_bit;
    logic [WIDTH-1:0] b_load;
    logic             carry_init;

    // Subtraction is a + ~b + 1, so only the B load value and the initial carry differ.
`ifdef SERIAL_ADD_SUB_EN
    assign b_load     = sub ? ~op_b : op_b;
    assign carry_init = sub;
`else
    assign b_load     = op_b;
    assign carry_init = 1'b0;
`endif

    // Full adder built from two half adders and an OR.
    assign ha1_s    = a_reg[0] ^ b_reg[0];
    assign ha1_c    = a_reg[0] & b_reg[0];
    assign fa_s     = ha1_s ^ carry_reg;
    assign ha2_c    = ha1_s & carry_reg;
    assign fa_c     = ha1_c | ha2_c;
    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
        end else if (state_reg == IDLE && in_valid) begin
            a_reg     <= op_a;
            b_reg     <= b_load;
            carry_reg <= carry_init;
            cnt_reg   <= '0;
        end else if (state_reg == RUN) begin
            a_reg     <= a_reg >> 1;
            b_reg     <= b_reg >> 1;
            sum_reg   <= {fa_s, sum_reg[WIDTH-1:1]};
            carry_reg <= fa_c;
            cnt_reg   <= cnt_reg + CW'(1);
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg == RUN);
    assign out_valid = (state_reg == DONE);
    assign sum       = sum_reg;
    assign cout      = carry_reg;

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: directed cases plus randomized traffic against a
// transaction-level model (result = a + b, or a - b when SERIAL_ADD_SUB_EN and sub are set).
module tb_serial_add_seq;

    localparam int WIDTH = 8;
`ifdef SERIAL_ADD_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, in_valid, out_ready, sub;
    logic [WIDTH-1:0] op_a, op_b;
    logic             in_ready, out_valid, cout, busy;
    logic [WIDTH-1:0] sum;

    int vectors    = 0;
    int miscompares = 0;

    serial_add_seq #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_a     (op_a),
        .op_b     (op_b),
`ifdef SERIAL_ADD_SUB_EN
        .sub      (sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: phase 0 idle, 1 computing, 2 result held.
    int               m_phase = 0;
    int               m_cnt   = 0;
    bit               model_ok = 1'b0;
    logic [WIDTH-1:0] m_sum = '0;
    logic             m_cout = 1'b0;
    logic [WIDTH:0]   m_pending = '0;
    logic [WIDTH-1:0] m_a, m_b;
    logic             m_s;

    always @(posedge clk) begin
        if (rst) begin
            m_phase  = 0;
            m_cnt    = 0;
            m_sum    = '0;
            m_cout   = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            case (m_phase)
                0: if (in_valid) begin
                    logic [WIDTH-1:0] nb;
                    int unsigned      total;
                    m_a   = op_a;
                    m_b   = op_b;
                    m_s   = SUB_EN && sub;
                    nb    = m_s ? ~op_b : op_b;
                    total = int'(op_a) + int'(nb) + (m_s ? 1 : 0);
                    m_pending = total[WIDTH:0];
                    m_cnt   = 0;
                    m_phase = 1;
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == WIDTH) begin
                        {m_cout, m_sum} = m_pending;
                        m_phase = 2;
                    end
                end
                default: if (out_ready) begin
                    $display("txn: a=0x%02h %s b=0x%02h -> sum=0x%02h cout=%0d", m_a, m_s ? "-" : "+", m_b, m_sum, m_cout);
                    m_phase = 0;
                end
            endcase
        end
    end

    // Per-cycle compare against the model; sum/cout are only defined outside the compute phase.
    always @(negedge clk) begin
        if (model_ok) begin
            check("in_ready",  {31'b0, in_ready},  {31'b0, m_phase == 0});
            check("busy",      {31'b0, busy},      {31'b0, m_phase == 1});
            check("out_valid", {31'b0, out_valid}, {31'b0, m_phase == 2});
            if (m_phase != 1) begin
                check("sum",  {24'b0, sum},   {24'b0, m_sum});
                check("cout", {31'b0, cout}, {31'b0, m_cout});
            end
        end
    end

    // Offer an operand pair from IDLE and wait for the result; counts edges from the accept edge.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                          output int edges, output int busy_n);
        edges  = 0;
        busy_n = 0;
        op_a = a; op_b = b; sub = s; in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (i == 0) in_valid = 1'b0;
            if (busy) busy_n++;
            if (out_valid) break;
        end
        if (!out_valid) check("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_after_ack", {31'b0, in_ready}, 32'd1);
    endtask

    int edges, busy_n;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy",      {31'b0, busy},      32'd0);
        check("rst_sum",       {24'b0, sum},       32'd0);
        check("rst_cout",      {31'b0, cout},      32'd0);

        run_op(8'h0F, 8'h01, 1'b0, edges, busy_n);
        check("lat_edges", edges, 32'd9);
        check("lat_busy",  busy_n, 32'd8);
        check("0F+01_sum", {24'b0, sum}, 32'h10);
        check("0F+01_cout", {31'b0, cout}, 32'd0);
        check("model_0F+01", {23'b0, m_cout, m_sum}, 32'h010);
        release_result();

        run_op(8'hFF, 8'h01, 1'b0, edges, busy_n);
        check("FF+01_sum", {24'b0, sum}, 32'h00);
        check("FF+01_cout", {31'b0, cout}, 32'd1);
        check("model_FF+01", {23'b0, m_cout, m_sum}, 32'h100);
        release_result();

        run_op(8'hAA, 8'h55, 1'b0, edges, busy_n);
        check("AA+55_sum", {24'b0, sum}, 32'hFF);
        check("AA+55_cout", {31'b0, cout}, 32'd0);
        // Hold the result while poking in_valid; nothing must be latched.
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            op_a = 8'h3C; op_b = 8'hC3;
            @(negedge clk);
            check("hold_sum", {24'b0, sum}, 32'hFF);
            check("hold_cout", {31'b0, cout}, 32'd0);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        release_result();
        @(negedge clk);
        check("idle_keeps_sum", {24'b0, sum}, 32'hFF);

        // Reset during the third compute cycle.
        op_a = 8'h33; op_b = 8'h44; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready",  {31'b0, in_ready},  32'd1);
        check("abort_busy",      {31'b0, busy},      32'd0);
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_sum",       {24'b0, sum},       32'd0);
        run_op(8'h01, 8'h02, 1'b0, edges, busy_n);
        check("01+02_sum", {24'b0, sum}, 32'h03);
        release_result();

`ifdef SERIAL_ADD_SUB_EN
        run_op(8'h05, 8'h07, 1'b1, edges, busy_n);
        check("05-07_sum", {24'b0, sum}, 32'hFE);
        check("05-07_cout", {31'b0, cout}, 32'd0);
        release_result();
        run_op(8'h07, 8'h05, 1'b1, edges, busy_n);
        check("07-05_sum", {24'b0, sum}, 32'h02);
        check("07-05_cout", {31'b0, cout}, 32'd1);
        release_result();
`endif

        // Randomized traffic: random offers, back-pressure and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            op_a      = WIDTH'($urandom);
            op_b      = WIDTH'($urandom);
            sub       = SUB_EN ? 1'($urandom) : 1'b0;
            out_ready = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_add_seq.md
SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 The module SHALL expose parameter WIDTH, default 8, operand/result width in bits (legal range 2..16).
REQ-002 The module SHALL have port clk input 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst input 1, reset; reset is synchronous and active-high.
REQ-004 The module SHALL have port in_valid input 1, operand pair offered.
REQ-005 The module SHALL have port in_ready output 1, sequencer can accept operands.
REQ-006 The module SHALL have port op_a input WIDTH, first operand.
REQ-007 The module SHALL have port op_b input WIDTH, second operand.
REQ-008 The module SHALL have port out_valid output 1, result held on sum/cout.
REQ-009 The module SHALL have port out_ready input 1, consumer accepts result.
REQ-010 The module SHALL have port sum output WIDTH, result bits.
REQ-011 The module SHALL have port cout output 1, final carry out of MSB.
REQ-012 The module SHALL have port busy output 1, high while in state RUN.

Function
REQ-013 The module SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-014 In IDLE, in_ready SHALL be 1; on an edge with in_valid=1, the module SHALL latch op_a/op_b into shift registers, clear the carry register, clear bit counter, and enter RUN.
REQ-015 In RUN, each cycle the module SHALL compute one bit using a single 1-bit full adder (two half-adders plus OR): s = a0^b0^c, c' = a0&b0 | c&(a0^b0), LSB first.
REQ-016 In RUN, each edge the module SHALL shift A and B right one bit, shift s into sum at the MSB, update carry, and increment the bit counter.
REQ-017 After exactly WIDTH RUN edges the module SHALL enter DONE; out_valid SHALL first be 1 in the cycle following the WIDTH-th RUN edge (WIDTH+1 edges after the accept edge).
REQ-018 In DONE, out_valid SHALL be 1, sum and cout SHALL hold stable, and on an edge with out_ready=1 the module SHALL return to IDLE.
REQ-019 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored and no operands latched.
REQ-020 out_ready while not in DONE SHALL have no effect.
REQ-021 Arithmetic SHALL be modulo 2^WIDTH on sum, with the carry out of bit WIDTH-1 on cout.
REQ-022 sum and cout SHALL retain the last result in IDLE until the next RUN overwrites them.

Reset
REQ-023 On a clock edge with rst=1 the FSM SHALL go to IDLE regardless of state, discarding any in-flight operation.
REQ-024 After reset: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, bit counter=0.
REQ-025 rst SHALL take priority over in_valid and out_ready on the same edge.

Configuration
REQ-026 Macro SERIAL_ADD_SUB_EN SHALL, when defined, add input port sub (1 bit) sampled with operands on the accept edge.
REQ-027 With SERIAL_ADD_SUB_EN and sub=1, the module SHALL use ~op_b and initial carry 1, producing op_a-op_b mod 2^WIDTH; cout=1 means no borrow.
REQ-028 Without SERIAL_ADD_SUB_EN, port sub SHALL not exist and the module SHALL only add with initial carry 0.

Verification
REQ-029 WIDTH=8, accept 0x0F+0x01 -> out_valid exactly 9 edges after accept, sum=0x10, cout=0, busy=1 for 8 cycles.
REQ-030 Accept 0xFF+0x01 -> sum=0x00, cout=1; 0xAA+0x55 -> sum=0xFF, cout=0.
REQ-031 Hold out_ready=0 for 5 cycles in DONE -> sum/cout stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-032 Assert rst on 3rd RUN cycle -> next cycle in_ready=1, busy=0, out_valid=0, sum=0; new op 0x01+0x02 -> sum=0x03.
REQ-033 With SERIAL_ADD_SUB_EN, sub=1: 0x05-0x07 -> sum=0xFE, cout=0; 0x07-0x05 -> sum=0x02, cout=1.
